reg_file_scoreboard: RTL
========================

Name: reg_file_scoreboard

Overview:
- Register file at the receiving end of the write-back stage. It accepts the selected write-back word (ALU result or immediate) and serves two combinational read ports to decode.
- Each register has a pending-write counter. Decode marks a destination busy at issue; write-back clears it.
- It raises a stall when decode reads a register whose newest value is not yet available.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; 2**ADDR_W registers (R0..R7)
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2**PEND_W-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- wb_en  in  1  write-back valid this cycle
- wb_addr  in  ADDR_W  write-back destination register
- wb_data  in  DATA_W  write-back word (already muxed ALU/immediate)
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data
- rd_data_b  out  DATA_W  read port B data
- src_a_used  in  1  decode actually consumes port A
- src_b_used  in  1  decode actually consumes port B
- issue_en  in  1  decode issues an instruction that writes issue_dst
- issue_dst  in  ADDR_W  destination of issuing instruction
- stall  out  1  decode must hold; issue suppressed
- sb_err  out  1  sticky scoreboard error flag

Behaviour:
- Reset: rst_n low at a rising edge sets all registers, all pending counters and sb_err to 0. Reads then return 0 and stall=0.
- Reset wins over every simultaneous wb_en or issue_en.
- Write: on a rising edge with wb_en=1, reg[wb_addr] <= wb_data. Latency is one edge. R0 is an ordinary writable register (no hard-wired zero).
- Read: rd_data_x is combinational from reg[rd_addr_x].
  - Bypass: if wb_en=1 and wb_addr==rd_addr_x in the same cycle, rd_data_x = wb_data.
- Pending counter cnt[r], updated each edge:
  - inc when (issue_en & ~stall & issue_dst==r)
  - dec when (wb_en & wb_addr==r)
  - inc and dec to the same r in the same cycle: count unchanged
  - inc at max (all ones): count holds and sb_err <= 1
  - dec at 0: count stays 0, the register write still occurs, sb_err <= 1
- sb_err is sticky until reset.
- Stall, combinational: stall = hz_a | hz_b, where
  - hz_x = src_x_used & (cnt[rd_addr_x] != 0) & ~(wb_en & wb_addr==rd_addr_x & cnt[rd_addr_x]==1)
  - i.e. no stall when the last outstanding write lands this cycle, because the bypass supplies its data.
- While stall=1, issue_en is ignored: no counter increment.
- issue_dst equal to a source register: the stall check uses cnt before this cycle's increment.
- Counter arithmetic is modulo-free: saturating as described above, never wraps.

Test Plan:
- Reset then read: rst_n=0 one edge, then rd_addr_a=3, rd_addr_b=5 -> rd_data_a=rd_data_b=0, stall=0, sb_err=0.
- Write then read: wb_en=1, wb_addr=2, wb_data=150 at edge N; rd_addr_a=2 at N+1 -> rd_data_a=150. Same cycle as the write, with rd_addr_b=2 -> rd_data_b=150 via bypass.
- RAW stall:
  - issue_en=1, issue_dst=4 at edge N; at N+1 src_a_used=1, rd_addr_a=4 -> stall=1.
  - Same cycle wb_en=1, wb_addr=4, wb_data=120 -> stall=0 and rd_data_a=120.
  - After that edge, cnt[4]=0.
- Two in flight: issue dst=1 twice (cnt=2); one wb to R1 with value 7 -> stall remains 1 that cycle. Second wb with value 9 -> stall=0, rd_data=9.
- Simultaneous issue/wb to R6 with cnt[6]=1 -> cnt stays 1. Suppressed issue while stall=1 -> cnt unchanged.
- Errors:
  - wb to R0 with cnt[0]=0 -> reg written and sb_err=1, staying 1 until rst_n=0.
  - Three issues to R3 then a fourth (PEND_W=2) -> cnt[3]=3 and sb_err=1.
- Mid-operation reset: with cnt[4]=2 and a pending stall, rst_n=0 -> next cycle stall=0 and all reads return 0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Write-back register file with two bypassed read ports and a per-register
// pending-write scoreboard that stalls decode on read-after-write hazards.
module reg_file_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              src_a_used,
    input  logic              src_b_used,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              stall,
    output logic              sb_err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] CNT_MAX  = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic              sb_err_q;
    logic              sb_err_d;
    logic              hz_a;
    logic              hz_b;

    // Read ports: a write landing this cycle is forwarded straight to decode.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (wb_en && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (wb_en && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

    // Hazard detection: the last outstanding write landing now is covered by the bypass.
    always_comb begin
        hz_a = src_a_used && (cnt_q[rd_addr_a] != CNT_ZERO)
               && !(wb_en && (wb_addr == rd_addr_a) && (cnt_q[rd_addr_a] == CNT_ONE));
        hz_b = src_b_used && (cnt_q[rd_addr_b] != CNT_ZERO)
               && !(wb_en && (wb_addr == rd_addr_b) && (cnt_q[rd_addr_b] == CNT_ONE));
        stall = hz_a || hz_b;
    end

    // Next-state for register contents, pending counters and the sticky error.
    always_comb begin
        logic inc;
        logic dec;
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREG; r++) begin
            inc = issue_en && !stall && (issue_dst == ADDR_W'(r));
            dec = wb_en && (wb_addr == ADDR_W'(r));
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (dec) begin
                regs_d[r] = wb_data;
            end else begin
                regs_d[r] = regs_q[r];
            end
            // Counters saturate at both ends; hitting either end is a scoreboard error.
            case ({inc, dec})
                2'b10: begin
                    if (cnt_q[r] == CNT_MAX) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_q[r] == CNT_ZERO) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule
